// File: rtl/dht11_reader_pkg.sv
// rtl/dht11_reader_pkg.sv - shared types and constants for the DHT11 reader
// Purpose: FSM state encoding, frame length and the frame checksum rule.
// Ports: none (package).
package dht11_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  localparam int FRAME_BITS = 40;

  // Sum of the four data bytes, modulo 256, must equal the trailing byte.
  function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/dht11_reader_us_tick_gen.sv
// rtl/dht11_reader_us_tick_gen.sv - 1 us tick prescaler
// Purpose: one-cycle pulse every CLK_HZ/1_000_000 clocks.
// Ports: clk (clock), reset (sync active-high), us_tick (1-cycle pulse).
module us_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic us_tick
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign us_tick = (cnt == LAST);

endmodule

// File: rtl/dht11_reader.sv
// rtl/dht11_reader.sv - periodic DHT11 single-wire conversion and frame decode
// Purpose: triggers a conversion every POLL_MS, decodes the 40-bit frame and
//   publishes the integral humidity and temperature bytes on checksum pass.
// Ports: clk, reset (sync active-high); dht_io (open-drain sensor line);
//   humidity, current_temperature (last good bytes); data_valid,
//   checksum_error, timeout_error (1-cycle pulses); busy (not IDLE).
module dht11_reader
  import dht11_reader_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int POLL_MS        = 2000,
  parameter int START_LOW_MS   = 18,
  parameter int TIMEOUT_US     = 200,
  parameter int BIT1_THRESH_US = 50
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        dht_io,
  output logic [7:0] humidity,
  output logic [7:0] current_temperature,
  output logic       data_valid,
  output logic       checksum_error,
  output logic       timeout_error,
  output logic       busy
);

  localparam logic [31:0] POLL_LAST   = 32'(POLL_MS * 1000 - 1);
  localparam logic [15:0] START_LAST  = 16'(START_LOW_MS * 1000 - 1);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_US - 1);
  localparam logic [16:0] BIT1_THRESH = 17'(BIT1_THRESH_US);
  localparam logic [5:0]  LAST_BIT    = 6'(FRAME_BITS - 1);

  state_t                  state;
  logic                    us_tick;
  logic [31:0]             poll_cnt;
  logic [15:0]             phase_cnt;
  logic [5:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    drive_low;
  logic                    dht_meta, dht_sync, dht_prev;
  logic                    fall, rise, timed_out, bit_val;
  logic [16:0]             eff_cnt;

  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .us_tick (us_tick)
  );

  assign dht_io = drive_low ? 1'b0 : 1'bz;
  assign busy   = (state != IDLE);

  // Idle line is high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      dht_meta <= 1'b1;
      dht_sync <= 1'b1;
      dht_prev <= 1'b1;
    end else begin
      dht_meta <= dht_io;
      dht_sync <= dht_meta;
      dht_prev <= dht_sync;
    end
  end

  assign fall = dht_prev & ~dht_sync;
  assign rise = ~dht_prev & dht_sync;

  // Count the tick landing in the deciding cycle too, so a high pulse of N us
  // measures exactly N regardless of prescaler phase.
  assign eff_cnt   = {1'b0, phase_cnt} + {16'd0, us_tick};
  assign bit_val   = (eff_cnt >= BIT1_THRESH);
  assign timed_out = us_tick && (phase_cnt >= TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      poll_cnt            <= '0;
      phase_cnt           <= '0;
      bit_cnt             <= '0;
      shreg               <= '0;
      drive_low           <= 1'b0;
      humidity            <= '0;
      current_temperature <= '0;
      data_valid          <= 1'b0;
      checksum_error      <= 1'b0;
      timeout_error       <= 1'b0;
    end else begin
      data_valid     <= 1'b0;
      checksum_error <= 1'b0;
      timeout_error  <= 1'b0;
      if (us_tick && phase_cnt != 16'hFFFF) begin
        phase_cnt <= phase_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (us_tick) begin
            if (poll_cnt == POLL_LAST) begin
              poll_cnt  <= '0;
              drive_low <= 1'b1;
              phase_cnt <= '0;
              state     <= START_LOW;
            end else begin
              poll_cnt <= poll_cnt + 32'd1;
            end
          end
        end
        START_LOW: begin
          if (us_tick && phase_cnt == START_LAST) begin
            drive_low <= 1'b0;
            phase_cnt <= '0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: begin
          // An edge wins over a timeout in the same cycle.
          if ((state == RESP_LOW || state == BIT_LOW) ? rise : fall) begin
            phase_cnt <= '0;
            case (state)
              WAIT_RESP: state <= RESP_LOW;
              RESP_LOW:  state <= RESP_HIGH;
              RESP_HIGH: begin
                bit_cnt <= '0;
                shreg   <= '0;
                state   <= BIT_LOW;
              end
              BIT_LOW:   state <= BIT_HIGH;
              default: begin
                shreg   <= {shreg[FRAME_BITS-2:0], bit_val};
                bit_cnt <= bit_cnt + 6'd1;
                state   <= (bit_cnt == LAST_BIT) ? CHECK : BIT_LOW;
              end
            endcase
          end else if (timed_out) begin
            timeout_error <= 1'b1;
            phase_cnt     <= '0;
            state         <= IDLE;
          end
        end
        CHECK: begin
          if (checksum_ok(shreg)) begin
            humidity            <= shreg[39:32];
            current_temperature <= shreg[23:16];
            data_valid          <= 1'b1;
          end else begin
            checksum_error <= 1'b1;
          end
          phase_cnt <= '0;
          state     <= IDLE;
        end
        default: begin
          drive_low <= 1'b0;
          phase_cnt <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
